mem_writer: RTL and testbench
=============================

# mem_writer

Byte-serial store engine for the CPU's memory stage, converting one 32-bit store request (byte, half or word) into consecutive single-byte writes on the 8-bit RAM port. It is the write-side counterpart of the instruction-fetch byte assembler: instead of gathering four sequential bytes into a word, it scatters a word into up to four sequential bytes, little-endian. It sits between the MEM stage and the RAM arbiter in the cpu module.

## Interface
Parameters: none.

- clk  input  1  system clock; all state updates on posedge
- rst  input  1  reset; asynchronous, active-high
- rdy  input  1  global ready; when low every register holds its value
- req_i  input  1  store request, single-cycle pulse, accepted only in IDLE with rdy high
- addr_i  input  32  byte address of the least-significant byte to store
- data_i  input  32  store data; bytes taken from data_i[7:0] upward
- size_i  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- busy_o  output  1  high from the cycle after acceptance until return to IDLE
- done_o  output  1  one-cycle pulse after the last byte is written
- addr_mem_o  output  32  RAM byte address
- d_mem_o  output  8  RAM write data
- wr_mem_o  output  1  RAM write enable (1 = write this cycle)

## Operation
- States: IDLE, WRITE, DONE. Internal: base address, data latch, 2-bit byte index k, 2-bit last index n (0, 1 or 3).
- IDLE, rdy=1, req_i=1: latch addr_i, data_i; n from size_i; k=0. Registered outputs: addr_mem_o=addr_i, d_mem_o=data_i[7:0], wr_mem_o=1, busy_o=1. Go to WRITE.
- WRITE, rdy=1: if k==n: wr_mem_o=0, done_o=1, go to DONE. Else k=k+1, addr_mem_o=addr_mem_o+1, d_mem_o=data byte k+1, wr_mem_o=1.
- DONE, rdy=1: done_o=0, busy_o=0, go to IDLE. req_i in DONE is ignored.
- req_i outside IDLE is ignored; no queuing. Requester waits for done_o before issuing the next store.
- Address increment is 32-bit modulo: 0xFFFFFFFF+1 = 0x00000000. No alignment check; misaligned stores write consecutive bytes.
- After completion addr_mem_o and d_mem_o hold the last written values; only wr_mem_o drops.
- rdy=0 in any state: all registers frozen, including wr_mem_o. A held write repeats the same byte to the same address, which is idempotent.
- rst=1 at any time, including mid-store: immediately IDLE. addr_mem_o=0, d_mem_o=0, wr_mem_o=0, busy_o=0, done_o=0, k=0. The aborted store is not resumed.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Request accepted at edge T. Byte b is presented during the cycle after edge T+b.
- Byte store: 1 write cycle; done_o high in cycle after edge T+1; IDLE after edge T+2.
- Halfword: 2 write cycles; done_o after edge T+2.
- Word: 4 write cycles; done_o after edge T+4.
- Minimum spacing between accepted requests: n+3 cycles.
- Each cycle with rdy low stretches the current state by exactly one cycle.
- busy_o and done_o are both high during the DONE cycle. busy_o is low in IDLE.

## Test plan
- Reset: assert rst asynchronously, with no clock edge -> all outputs 0, busy_o 0.
- Word store: addr_i=0x1000, data_i=0xDEADBEEF, size_i=10 -> writes (0x1000,EF), (0x1001,BE), (0x1002,AD), (0x1003,DE) on 4 consecutive cycles; done_o pulses once, one cycle later.
- Byte and halfword stores: size 00 at 0x20 with data 0x12345678 -> a single write of 0x78. size 01 at 0x31 with data 0xAABBCCDD -> writes (0x31,DD), (0x32,CC), then done_o.
- Wrap-around: word store at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rdy stall and ignored request: word store with rdy low for 2 cycles after the second byte -> byte 1 is held on the port for 3 cycles and total latency grows by 2. req_i pulsed while busy -> no effect, and exactly 4 writes occur.
- Reset mid-operation: rst during the third byte of a word store -> wr_mem_o drops immediately and the block stays IDLE. A new byte request then completes normally.

Source files
------------

// File: rtl/mem_writer.sv
// Byte-serial store engine: scatters one byte/half/word store into consecutive
// little-endian single-byte writes on the 8-bit RAM port.
module mem_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] addr_mem_o,
    output logic [7:0]  d_mem_o,
    output logic        wr_mem_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  k_nxt;
    logic [7:0]  byte_nxt;

    assign k_nxt = k_q + 2'd1;

    always_comb begin
        case (k_nxt)
            2'd1:    byte_nxt = data_q[15:8];
            2'd2:    byte_nxt = data_q[23:16];
            2'd3:    byte_nxt = data_q[31:24];
            default: byte_nxt = data_q[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        k_d     = k_q;
        n_d     = n_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        // rdy low leaves every register at its current value
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        state_d = S_WRITE;
                        data_d  = data_i;
                        k_d     = 2'd0;
                        n_d     = (size_i == 2'b00) ? 2'd0 :
                                  (size_i == 2'b01) ? 2'd1 : 2'd3;
                        addr_d  = addr_i;
                        dout_d  = data_i[7:0];
                        wr_d    = 1'b1;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                S_WRITE: begin
                    if (k_q == n_q) begin
                        state_d = S_DONE;
                        wr_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d    = k_nxt;
                        addr_d = addr_q + 32'd1;
                        dout_d = byte_nxt;
                        wr_d   = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            k_q     <= k_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign addr_mem_o = addr_q;
    assign d_mem_o    = dout_q;
    assign wr_mem_o   = wr_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed table-driven bench for mem_writer plus stall and mid-store reset sequences.
module tb_mem_writer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] addr_mem_o;
    logic [7:0]  d_mem_o;
    logic        wr_mem_o;

    int checks;
    int failures;

    mem_writer dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .size_i     (size_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .addr_mem_o (addr_mem_o),
        .d_mem_o    (d_mem_o),
        .wr_mem_o   (wr_mem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [1:0]       size;
        int unsigned      nwr;
        logic [3:0][31:0] exp_addr;
        logic [3:0][7:0]  exp_byte;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic wr, input logic [31:0] a,
                              input logic [7:0] d, input logic busy, input logic done);
        check({tag, ".wr"},   {31'd0, wr_mem_o}, {31'd0, wr});
        check({tag, ".addr"}, addr_mem_o, a);
        check({tag, ".data"}, {24'd0, d_mem_o}, {24'd0, d});
        check({tag, ".busy"}, {31'd0, busy_o}, {31'd0, busy});
        check({tag, ".done"}, {31'd0, done_o}, {31'd0, done});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        addr_i = v.addr;
        data_i = v.data;
        size_i = v.size;
        req_i  = 1'b1;
        tick();
        req_i  = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        for (int unsigned b = 0; b < v.nwr; b++) begin
            check_port($sformatf("%s.b%0d", tag, b), 1'b1, v.exp_addr[b], v.exp_byte[b], 1'b1, 1'b0);
            tick();
        end
        check_port({tag, ".done"}, 1'b0, v.exp_addr[v.nwr-1], v.exp_byte[v.nwr-1], 1'b1, 1'b1);
        tick();
        check_port({tag, ".idle"}, 1'b0, v.exp_addr[v.nwr-1], v.exp_byte[v.nwr-1], 1'b0, 1'b0);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;

        vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 4,
                    {32'h0000_1003, 32'h0000_1002, 32'h0000_1001, 32'h0000_1000},
                    {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[1] = '{32'h0000_0020, 32'h1234_5678, 2'b00, 1,
                    {32'h0, 32'h0, 32'h0, 32'h0000_0020},
                    {8'h00, 8'h00, 8'h00, 8'h78}};
        vecs[2] = '{32'h0000_0031, 32'hAABB_CCDD, 2'b01, 2,
                    {32'h0, 32'h0, 32'h0000_0032, 32'h0000_0031},
                    {8'h00, 8'h00, 8'hCC, 8'hDD}};
        vecs[3] = '{32'hFFFF_FFFE, 32'h0102_0304, 2'b10, 4,
                    {32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
                    {8'h01, 8'h02, 8'h03, 8'h04}};
        vecs[4] = '{32'h0000_0200, 32'hCAFE_F00D, 2'b11, 4,
                    {32'h0000_0203, 32'h0000_0202, 32'h0000_0201, 32'h0000_0200},
                    {8'hCA, 8'hFE, 8'hF0, 8'h0D}};

        rst    = 1'b0;
        rdy    = 1'b1;
        req_i  = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        size_i = 2'b00;

        // Asynchronous reset before the first clock edge
        #2 rst = 1'b1;
        #1;
        check_port("reset", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_port("post_reset", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stall two cycles on byte 1, with ignored requests while busy and in DONE
        addr_i = 32'h0000_1000; data_i = 32'hDEAD_BEEF; size_i = 2'b10; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        check_port("stall.b0", 1'b1, 32'h1000, 8'hEF, 1'b1, 1'b0);
        tick();
        check_port("stall.b1a", 1'b1, 32'h1001, 8'hBE, 1'b1, 1'b0);
        rdy = 1'b0;
        tick();
        check_port("stall.b1b", 1'b1, 32'h1001, 8'hBE, 1'b1, 1'b0);
        addr_i = 32'h0000_5000; data_i = 32'h1111_2222; size_i = 2'b00; req_i = 1'b1;
        tick();
        check_port("stall.b1c", 1'b1, 32'h1001, 8'hBE, 1'b1, 1'b0);
        rdy = 1'b1;
        tick();
        req_i = 1'b0;
        check_port("stall.b2", 1'b1, 32'h1002, 8'hAD, 1'b1, 1'b0);
        tick();
        check_port("stall.b3", 1'b1, 32'h1003, 8'hDE, 1'b1, 1'b0);
        tick();
        check_port("stall.done", 1'b0, 32'h1003, 8'hDE, 1'b1, 1'b1);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        check_port("stall.idle", 1'b0, 32'h1003, 8'hDE, 1'b0, 1'b0);
        tick();
        check_port("stall.idle2", 1'b0, 32'h1003, 8'hDE, 1'b0, 1'b0);

        // Reset during the third byte of a word store
        addr_i = 32'h0000_1000; data_i = 32'hDEAD_BEEF; size_i = 2'b10; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        tick();
        check_port("abort.b2", 1'b1, 32'h1002, 8'hAD, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_port("abort.rst", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        tick();
        check_port("abort.idle1", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        tick();
        check_port("abort.idle2", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);

        v = '{32'h0000_0040, 32'h0000_00A5, 2'b00, 1,
              {32'h0, 32'h0, 32'h0, 32'h0000_0040},
              {8'h00, 8'h00, 8'h00, 8'hA5}};
        run_vec(v, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
